// File: rtl/board_mem.sv
// Cell-board register store: write port from the write-source switch, registered read port,
// self-timed clear sequencer and live nonzero-cell count. Optional per-cell locks: BOARD_LOCK_EN.
module board_mem #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int VAL_W  = 5,
  parameter int CNT_W  = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       cell_x,
  input  logic [3:0]       cell_y,
  input  logic             we,
  input  logic [VAL_W-1:0] new_value,
  input  logic             clear_req,
  input  logic [3:0]       rd_x,
  input  logic [3:0]       rd_y,
`ifdef BOARD_LOCK_EN
  input  logic             lock_in,
  output logic             wr_rejected,
`endif
  output logic [VAL_W-1:0] rd_value,
  output logic             busy,
  output logic             wr_done,
  output logic [CNT_W-1:0] nonzero_count
);
  localparam int CELLS  = GRID_W * GRID_H;
  localparam int ADDR_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [4:0] W_LIM = 5'(GRID_W);
  localparam logic [4:0] H_LIM = 5'(GRID_H);
  localparam logic [7:0] W_MUL = 8'(GRID_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] clr_ptr;
  logic [VAL_W-1:0]  mem [CELLS];

  // Linear index in 8 bits: the largest legal board (16x16) tops out at 255.
  function automatic logic [7:0] lin(input logic [3:0] x, input logic [3:0] y);
    return ({4'b0, y} * W_MUL) + {4'b0, x};
  endfunction

  logic [7:0]        wr_lin, rd_lin;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              wr_in, rd_in, wr_hit, wr_acc;
  logic [VAL_W-1:0]  old_val;

  assign wr_lin  = lin(cell_x, cell_y);
  assign rd_lin  = lin(rd_x, rd_y);
  assign wr_addr = wr_lin[ADDR_W-1:0];
  assign rd_addr = rd_lin[ADDR_W-1:0];
  assign wr_in   = ({1'b0, cell_x} < W_LIM) && ({1'b0, cell_y} < H_LIM);
  assign rd_in   = ({1'b0, rd_x} < W_LIM) && ({1'b0, rd_y} < H_LIM);
  // clear_req outranks a simultaneous write
  assign wr_hit  = (state_q == IDLE) && !clear_req && we && wr_in;
  assign old_val = mem[wr_addr];

`ifdef BOARD_LOCK_EN
  logic [CELLS-1:0] lock;
  logic             wr_rej;
  assign wr_acc = wr_hit && !lock[wr_addr];
  assign wr_rej = wr_hit &&  lock[wr_addr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR)     lock[clr_ptr] <= 1'b0;
      else if (wr_acc && lock_in) lock[wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wr_rejected <= 1'b0;
    else     wr_rejected <= wr_rej;
  end
`else
  assign wr_acc = wr_hit;
`endif

  always_comb begin
    state_d = state_q;
    busy    = (state_q == CLEAR);
    case (state_q)
      IDLE:    if (clear_req) state_d = CLEAR;
      CLEAR:   if (clr_ptr == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CLEAR;
      clr_ptr       <= '0;
      wr_done       <= 1'b0;
      rd_value      <= '0;
      nonzero_count <= '0;
    end else begin
      state_q  <= state_d;
      clr_ptr  <= (state_q == CLEAR && clr_ptr != LAST) ? clr_ptr + ADDR_W'(1) : '0;
      wr_done  <= wr_acc;
      rd_value <= rd_in ? mem[rd_addr] : '0;
      // Count drops to 0 as soon as a clear is entered and stays there until it ends.
      if (state_q == CLEAR || clear_req)
        nonzero_count <= '0;
      else if (wr_acc) begin
        if (old_val == '0 && new_value != '0)
          nonzero_count <= nonzero_count + CNT_W'(1);
        else if (old_val != '0 && new_value == '0)
          nonzero_count <= nonzero_count - CNT_W'(1);
      end
    end
  end

  // Storage has no reset; the clear sequence launched by rst defines it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) mem[clr_ptr] <= '0;
      else if (wr_acc)      mem[wr_addr] <= new_value;
    end
  end
endmodule

// File: tb/tb_board_mem.sv
// Bench for board_mem: scoreboarded vector table on a 16x16 board, plus clear/reset
// sequences and out-of-range checks on a second 12x10 instance.
module tb_board_mem;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cell_x, cell_y, rd_x, rd_y;
  logic       we, clear_req;
  logic [4:0] new_value, rd_value;
  logic       busy, wr_done;
  logic [8:0] nonzero_count;
`ifdef BOARD_LOCK_EN
  logic lock_in, wr_rejected, lock2, wr_rej2;
`endif
  logic [3:0] x2, y2, rx2, ry2;
  logic       we2, clr2, busy2, wd2;
  logic [4:0] v2, rd2;
  logic [8:0] cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  board_mem dut (
    .clk(clk), .rst(rst), .cell_x(cell_x), .cell_y(cell_y), .we(we),
    .new_value(new_value), .clear_req(clear_req), .rd_x(rd_x), .rd_y(rd_y),
`ifdef BOARD_LOCK_EN
    .lock_in(lock_in), .wr_rejected(wr_rejected),
`endif
    .rd_value(rd_value), .busy(busy), .wr_done(wr_done), .nonzero_count(nonzero_count)
  );

  board_mem #(.GRID_W(12), .GRID_H(10)) dut2 (
    .clk(clk), .rst(rst), .cell_x(x2), .cell_y(y2), .we(we2),
    .new_value(v2), .clear_req(clr2), .rd_x(rx2), .rd_y(ry2),
`ifdef BOARD_LOCK_EN
    .lock_in(lock2), .wr_rejected(wr_rej2),
`endif
    .rd_value(rd2), .busy(busy2), .wr_done(wd2), .nonzero_count(cnt2)
  );

  typedef struct {
    string      nm;
    logic       w;
    logic [3:0] x, y;
    logic [4:0] v;
    logic       c;
    logic [3:0] rx, ry;
    int         rd;   // -1: don't check
    int         wd, cnt, bsy;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input int w, input int x, input int y,
                              input int v, input int c, input int rx, input int ry,
                              input int rd, input int wd, input int cnt, input int bsy);
    vec_t t;
    t.nm = nm; t.w = w[0]; t.x = 4'(x); t.y = 4'(y); t.v = 5'(v); t.c = c[0];
    t.rx = 4'(rx); t.ry = 4'(ry); t.rd = rd; t.wd = wd; t.cnt = cnt; t.bsy = bsy;
    return t;
  endfunction

  // Drive one vector, queue its expectation, compare after the next rising edge.
  task automatic apply(input vec_t t);
    vec_t e;
    we = t.w; cell_x = t.x; cell_y = t.y; new_value = t.v;
    clear_req = t.c; rd_x = t.rx; rd_y = t.ry;
    sb.push_back(t);
    @(posedge clk); @(negedge clk);
    e = sb.pop_front();
    if (e.rd >= 0) chk({e.nm, ".rd_value"}, int'(rd_value), e.rd);
    chk({e.nm, ".wr_done"}, int'(wr_done), e.wd);
    chk({e.nm, ".count"}, int'(nonzero_count), e.cnt);
    chk({e.nm, ".busy"}, int'(busy), e.bsy);
    we = 1'b0; clear_req = 1'b0;
  endtask

  // Count samples with busy high; optionally hammer we/clear_req while clearing.
  task automatic wait_clear(input bit poke, output int n, output int viol);
    n = 0; viol = 0;
    while (busy && n < 1000) begin
      n++;
      if (poke) begin
        we = 1'b1; cell_x = 4'd7; cell_y = 4'd7; new_value = 5'd12; clear_req = n[0];
      end
      @(posedge clk); @(negedge clk);
      if (wr_done || nonzero_count != 0) viol++;
    end
    we = 1'b0; clear_req = 1'b0;
  endtask

  task automatic step2(input int w, input int x, input int y, input int v,
                       input int rx, input int ry);
    we2 = w[0]; x2 = 4'(x); y2 = 4'(y); v2 = 5'(v); rx2 = 4'(rx); ry2 = 4'(ry);
    @(posedge clk); @(negedge clk);
    we2 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, viol;
    we = 0; clear_req = 0; cell_x = 0; cell_y = 0; new_value = 0; rd_x = 0; rd_y = 0;
    we2 = 0; clr2 = 0; x2 = 0; y2 = 0; v2 = 0; rx2 = 0; ry2 = 0;
`ifdef BOARD_LOCK_EN
    lock_in = 0; lock2 = 0;
`endif

    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("reset.busy", int'(busy), 1);
    chk("reset.wr_done", int'(wr_done), 0);
    chk("reset.rd_value", int'(rd_value), 0);
    chk("reset.count", int'(nonzero_count), 0);
    rst = 1'b0;
    wait_clear(1'b0, n, viol);
    chk("init_clear.cycles", n, 256);

    tbl.push_back(mk("w35_17", 1, 3, 5, 17, 0, 3, 5,  0, 1, 1, 0));
    tbl.push_back(mk("rd35",   0, 0, 0,  0, 0, 3, 5, 17, 0, 1, 0));
    tbl.push_back(mk("w35_0",  1, 3, 5,  0, 0, 3, 5, 17, 1, 0, 0));
    tbl.push_back(mk("w35_9a", 1, 3, 5,  9, 0, 0, 0,  0, 1, 1, 0));
    tbl.push_back(mk("w35_9b", 1, 3, 5,  9, 0, 3, 5,  9, 1, 1, 0));
    tbl.push_back(mk("wff_31", 1, 15, 15, 31, 0, 15, 15, 0, 1, 2, 0));
    tbl.push_back(mk("wff_5",  1, 15, 15, 5, 0, 15, 15, 31, 1, 2, 0));
    tbl.push_back(mk("w00_0",  1, 0, 0,  0, 0, 15, 15, 5, 1, 2, 0));
    tbl.push_back(mk("rd35b",  0, 0, 0,  0, 0, 3, 5,  9, 0, 2, 0));
    tbl.push_back(mk("w0f_1",  1, 0, 15, 1, 0, 15, 0, 0, 1, 3, 0));
    tbl.push_back(mk("rd0f",   0, 0, 0,  0, 0, 0, 15, 1, 0, 3, 0));
    tbl.push_back(mk("rdf0",   0, 0, 0,  0, 0, 15, 0, 0, 0, 3, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // write + clear_req together: write dropped, clear starts
    apply(mk("wr_and_clr", 1, 7, 7, 12, 1, 7, 7, 0, 0, 0, 1));
    wait_clear(1'b1, n, viol);
    chk("clr_req.cycles", n, 256);
    chk("clr_req.ignored_inputs", viol, 0);
    apply(mk("post_clr77", 0, 0, 0, 0, 0, 7, 7, 0, 0, 0, 0));
    apply(mk("post_clr35", 0, 0, 0, 0, 0, 3, 5, 0, 0, 0, 0));
    apply(mk("post_clrff", 0, 0, 0, 0, 0, 15, 15, 0, 0, 0, 0));

    // reset at clr_ptr=100 restarts the sweep
    apply(mk("clr_start", 0, 0, 0, 0, 1, 0, 0, -1, 0, 0, 1));
    repeat (100) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("mid_rst.busy", int'(busy), 1);
    wait_clear(1'b0, n, viol);
    chk("mid_rst.cycles", n, 256);

`ifdef BOARD_LOCK_EN
    lock_in = 1'b1;
    apply(mk("lock_w4", 1, 1, 1, 4, 0, 1, 1, 0, 1, 1, 0));
    lock_in = 1'b0;
    apply(mk("lock_w7", 1, 1, 1, 7, 0, 1, 1, 4, 0, 1, 0));
    chk("lock.wr_rejected", int'(wr_rejected), 1);
    apply(mk("lock_rd", 0, 0, 0, 0, 0, 1, 1, 4, 0, 1, 0));
    chk("lock.rej_pulse", int'(wr_rejected), 0);
    apply(mk("lock_clr", 0, 0, 0, 0, 1, 0, 0, -1, 0, 0, 1));
    wait_clear(1'b0, n, viol);
    apply(mk("unlock_w7", 1, 1, 1, 7, 0, 0, 0, 0, 1, 1, 0));
    apply(mk("unlock_rd", 0, 0, 0, 0, 0, 1, 1, 7, 0, 1, 0));
`endif

    // 12x10 instance: clear length and out-of-range handling
    clr2 = 1'b1;
    @(posedge clk); @(negedge clk);
    clr2 = 1'b0;
    n = 0;
    while (busy2 && n < 1000) begin
      n++;
      @(posedge clk); @(negedge clk);
    end
    chk("g12.clear_cycles", n, 120);
    step2(1, 0, 1, 6, 0, 0);
    chk("g12.w01.wr_done", int'(wd2), 1);
    chk("g12.w01.count", int'(cnt2), 1);
    step2(1, 12, 0, 5, 12, 0);
    chk("g12.x_oor.wr_done", int'(wd2), 0);
    chk("g12.x_oor.count", int'(cnt2), 1);
    chk("g12.x_oor.rd_value", int'(rd2), 0);
    step2(1, 0, 10, 5, 0, 1);
    chk("g12.y_oor.wr_done", int'(wd2), 0);
    chk("g12.y_oor.count", int'(cnt2), 1);
    chk("g12.alias01.rd_value", int'(rd2), 6);
    step2(1, 11, 9, 3, 11, 9);
    chk("g12.wmax.wr_done", int'(wd2), 1);
    chk("g12.wmax.count", int'(cnt2), 2);
    chk("g12.wmax.rd_old", int'(rd2), 0);
    step2(0, 0, 0, 0, 11, 9);
    chk("g12.rdmax", int'(rd2), 3);
    step2(0, 0, 0, 0, 0, 10);
    chk("g12.rd_oor", int'(rd2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
